// File: rtl/uart_cmd_parser.sv
// Frame controller: assembles UART bytes into register write strobes.
// Define UART_CMD_CHECKSUM_EN to append and verify an XOR checksum byte.
module uart_cmd_parser #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] HEADER     = 8'hAA,
    parameter int         TIMEOUT    = 4000
) (
    input  logic                    bclk,
    input  logic                    rst,
    input  logic                    rx_done,
    input  logic [7:0]              rx_dout,
    output logic                    wr_en,
    output logic [7:0]              wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
`ifdef UART_CMD_CHECKSUM_EN
        CHK   = 3'd3,
`endif
        WRITE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_done_q, rx_done_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [7:0]    addr_sh_q, addr_sh_d;
    logic [DW-1:0] data_sh_q, data_sh_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          frame_err_q, frame_err_d;

    logic          ev;
    logic          tmo;
    logic [DW-1:0] data_nx;

    // armed_q blocks a level left high across reset release from
    // being mistaken for a fresh byte
    assign ev      = rx_done & ~rx_done_q & armed_q;
    assign tmo     = ~ev & (tcnt_q == TW'(TIMEOUT - 1));
    assign data_nx = (data_sh_q << 8) | DW'(rx_dout);

    always_comb begin
        state_d     = state_q;
        rx_done_d   = rx_done;
        armed_d     = armed_q | ~rx_done;
        tcnt_d      = tcnt_q + TW'(1);
        bcnt_d      = bcnt_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
`ifdef UART_CMD_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        if (ev || state_q == IDLE) begin
            tcnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (ev && rx_dout == HEADER) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ev) begin
                    addr_sh_d = rx_dout;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d     = rx_dout;
`endif
                    bcnt_d    = '0;
                    state_d   = DATA;
                end else if (tmo) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DATA: begin
                if (ev) begin
                    data_sh_d = data_nx;
`ifdef UART_CMD_CHECKSUM_EN
                    chk_d     = chk_q ^ rx_dout;
`endif
                    bcnt_d    = bcnt_q + BW'(1);
                    if (bcnt_q == BW'(DATA_BYTES - 1)) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d   = CHK;
`else
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_sh_q;
                        wr_data_d = data_nx;
`endif
                    end
                end else if (tmo) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            CHK: begin
                if (ev) begin
                    if (rx_dout == chk_q) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_sh_q;
                        wr_data_d = data_sh_q;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmo) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            // outputs were loaded on entry so they coincide with wr_en
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rx_done_q   <= 1'b0;
            armed_q     <= 1'b0;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q       <= '0;
`endif
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_done_q   <= rx_done_d;
            armed_q     <= armed_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
`ifdef UART_CMD_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame table, corner sequences and a
// randomized byte stream checked against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int         DB  = 4;
    localparam int         TO  = 20;
    localparam logic [7:0] HDR = 8'hAA;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int FL = 2 + DB + (CHK_EN ? 1 : 0);

    typedef logic [7:0] bq_t[$];

    logic        bclk;
    logic        rst;
    logic        rx_done;
    logic [7:0]  rx_dout;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;
    logic        busy;

    uart_cmd_parser #(
        .DATA_BYTES(DB),
        .HEADER    (HDR),
        .TIMEOUT   (TO)
    ) dut (
        .bclk     (bclk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_dout  (rx_dout),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ev = 0;

    int wr_cnt = 0;
    int err_cnt = 0;
    int wr_cyc = 0;
    int err_cyc = 0;
    int both_hi = 0;
    logic busy_prev = 1'b0;
    logic busy_at_err = 1'b0;
    logic busy_before = 1'b0;
    logic [39:0] wr_q[$];

    always @(posedge bclk) cyc <= cyc + 1;

    always @(negedge bclk) begin
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
            wr_q.push_back({wr_addr, wr_data});
        end
        if (frame_err) begin
            err_cnt     <= err_cnt + 1;
            err_cyc     <= cyc;
            busy_at_err <= busy;
            busy_before <= busy_prev;
        end
        if (wr_en && frame_err) both_hi <= both_hi + 1;
        busy_prev <= busy;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold,
                             input int gap);
        @(negedge bclk);
        rx_dout = b;
        rx_done = 1'b1;
        last_ev = cyc;
        repeat (hold) @(negedge bclk);
        rx_done = 1'b0;
        rx_dout = 8'($urandom);
        repeat (gap) @(negedge bclk);
    endtask

    function automatic bq_t mk_frame(input logic [7:0] a,
                                     input logic [31:0] d, input bit bad);
        bq_t q;
        logic [7:0] x;
        q.push_back(HDR);
        q.push_back(a);
        x = a;
        for (int i = DB - 1; i >= 0; i--) begin
            q.push_back(d[8*i +: 8]);
            x ^= d[8*i +: 8];
        end
        if (CHK_EN) q.push_back(x ^ (bad ? 8'hFF : 8'h00));
        return q;
    endfunction

    // reference model: frame-position bookkeeping over the byte stream
    bit          m_act = 1'b0;
    logic [7:0]  m_fr[$];
    logic [39:0] exp_q[$];
    int          exp_err = 0;
    int          prev_ev = 0;

    function automatic void model_byte(input logic [7:0] b, input int d);
        logic [7:0]  x;
        logic [31:0] dat;
        if (m_act && d > TO) begin
            exp_err++;
            m_act = 1'b0;
        end
        if (!m_act) begin
            if (b == HDR) begin
                m_act = 1'b1;
                m_fr.delete();
            end
        end else begin
            m_fr.push_back(b);
            if (m_fr.size() == FL - 1) begin
                x = 8'h00;
                dat = 32'h0;
                for (int i = 0; i <= DB; i++) x ^= m_fr[i];
                for (int i = 1; i <= DB; i++) dat = {dat[23:0], m_fr[i]};
                if (!CHK_EN || m_fr[DB+1] == x)
                    exp_q.push_back({m_fr[0], dat});
                else
                    exp_err++;
                m_act = 1'b0;
            end
        end
    endfunction

    task automatic send_m(input logic [7:0] b, input int gap);
        send_byte(b, $urandom_range(1, 4), gap);
        model_byte(b, last_ev - prev_ev);
        prev_ev = last_ev;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  pre0;
        logic [7:0]  pre1;
        int          npre;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          bad;
        int          hold;
        int          exp_wr;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_err;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  f;
        int   w0, e0, k, wq0;
        logic [7:0]  a;
        logic [31:0] d;

        vt[0] = '{"basic", 8'h00, 8'h00, 0, 8'h10, 32'h12345678, 1'b0, 1,
                  1, 8'h10, 32'h12345678, 0};
        vt[1] = '{"stray", 8'h55, 8'h00, 2, 8'h01, 32'hDEADBEEF, 1'b0, 1,
                  1, 8'h01, 32'hDEADBEEF, 0};
`ifdef UART_CMD_CHECKSUM_EN
        vt[2] = '{"badchk", 8'h00, 8'h00, 0, 8'h10, 32'h12345678, 1'b1, 1,
                  0, 8'h01, 32'hDEADBEEF, 1};
`else
        vt[2] = '{"badchk", 8'h00, 8'h00, 0, 8'h10, 32'h12345678, 1'b1, 1,
                  1, 8'h10, 32'h12345678, 0};
`endif
        vt[3] = '{"hold7", 8'h00, 8'h00, 0, 8'h20, 32'hAAAAAAAA, 1'b0, 7,
                  1, 8'h20, 32'hAAAAAAAA, 0};
        vt[4] = '{"hdr_addr", 8'h13, 8'h00, 1, 8'hAA, 32'h00AA0055, 1'b0, 2,
                  1, 8'hAA, 32'h00AA0055, 0};

        // reset with rx_done already high: release must not create an event
        rst = 1'b0;
        rx_done = 1'b1;
        rx_dout = HDR;
        repeat (3) @(negedge bclk);
        check("reset_outputs", {wr_en, wr_addr, wr_data, frame_err, busy}, 0);
        rst = 1'b1;
        repeat (5) @(negedge bclk);
        check("held_level_busy", busy, 0);
        rx_done = 1'b0;
        repeat (3) @(negedge bclk);
        check("held_level_busy2", busy, 0);
        check("held_level_wr", wr_cnt, 0);

        foreach (vt[i]) begin
            w0 = wr_cnt;
            e0 = err_cnt;
            if (vt[i].npre > 0) send_byte(vt[i].pre0, vt[i].hold, 2);
            if (vt[i].npre > 1) send_byte(vt[i].pre1, vt[i].hold, 2);
            f = mk_frame(vt[i].addr, vt[i].data, vt[i].bad);
            foreach (f[j]) send_byte(f[j], vt[i].hold, 2);
            repeat (5) @(negedge bclk);
            check({vt[i].name, "_wr"}, wr_cnt - w0, vt[i].exp_wr);
            check({vt[i].name, "_err"}, err_cnt - e0, vt[i].exp_err);
            check({vt[i].name, "_addr"}, wr_addr, vt[i].exp_addr);
            check({vt[i].name, "_data"}, wr_data, vt[i].exp_data);
            if (vt[i].exp_wr == 1)
                check({vt[i].name, "_lat"}, wr_cyc - last_ev, 1);
        end

        // truncated frame times out, then a full frame is accepted
        w0 = wr_cnt;
        e0 = err_cnt;
        send_byte(HDR, 1, 2);
        send_byte(8'h10, 1, 2);
        send_byte(8'h12, 1, 0);
        k = 0;
        while (err_cnt == e0 && k < TO + 10) begin
            @(negedge bclk);
            k++;
        end
        @(negedge bclk);
        check("to_seen", err_cnt - e0, 1);
        check("to_cycle", err_cyc - last_ev, TO + 1);
        check("to_busy_after", busy_at_err, 0);
        check("to_busy_before", busy_before, 1);
        check("to_no_wr", wr_cnt - w0, 0);
        f = mk_frame(8'h44, 32'hCAFEF00D, 1'b0);
        foreach (f[j]) send_byte(f[j], 1, 1);
        repeat (4) @(negedge bclk);
        check("to_next_wr", wr_cnt - w0, 1);
        check("to_next_data", {wr_addr, wr_data}, {8'h44, 32'hCAFEF00D});

        // gap of exactly TO cycles is still inside the frame
        w0 = wr_cnt;
        e0 = err_cnt;
        f = mk_frame(8'h5A, 32'h01020304, 1'b0);
        foreach (f[j]) send_byte(f[j], 1, (j == 1) ? TO - 2 : 1);
        repeat (4) @(negedge bclk);
        check("edge_to_wr", wr_cnt - w0, 1);
        check("edge_to_err", err_cnt - e0, 0);

        // one cycle longer expires; the tail lands in IDLE and is dropped
        w0 = wr_cnt;
        e0 = err_cnt;
        f = mk_frame(8'h6B, 32'h11223344, 1'b0);
        foreach (f[j]) send_byte(f[j], 1, (j == 1) ? TO - 1 : 1);
        repeat (4) @(negedge bclk);
        check("over_to_wr", wr_cnt - w0, 0);
        check("over_to_err", err_cnt - e0, 1);
        check("over_to_hold", {wr_addr, wr_data}, {8'h5A, 32'h01020304});

        // reset mid-frame clears everything at once
        send_byte(HDR, 1, 1);
        send_byte(8'h10, 1, 1);
        send_byte(8'h12, 1, 0);
        #3 rst = 1'b0;
        #1 check("mid_reset", {wr_en, wr_addr, wr_data, frame_err, busy}, 0);
        repeat (2) @(negedge bclk);
        rst = 1'b1;
        w0 = wr_cnt;
        f = mk_frame(8'h33, 32'h0BADCAFE, 1'b0);
        foreach (f[j]) send_byte(f[j], 1, 1);
        repeat (4) @(negedge bclk);
        check("post_reset_wr", wr_cnt - w0, 1);
        check("post_reset_data", {wr_addr, wr_data}, {8'h33, 32'h0BADCAFE});

        // randomized stream against the reference model
        wq0 = wr_q.size();
        e0 = err_cnt;
        prev_ev = last_ev;
        for (int it = 0; it < 40; it++) begin
            a = 8'($urandom);
            d = $urandom;
            case ($urandom_range(0, 3))
                0: send_m((8'($urandom) == HDR) ? 8'h00 : 8'h7E,
                          $urandom_range(0, 4));
                1: begin
                    f = mk_frame(a, d, 1'b0);
                    foreach (f[j]) send_m(f[j], $urandom_range(0, 4));
                end
                2: begin
                    f = mk_frame(a, d, 1'b1);
                    foreach (f[j]) send_m(f[j], $urandom_range(0, 4));
                end
                default: begin
                    f = mk_frame(a, d, 1'b0);
                    k = $urandom_range(1, FL - 1);
                    for (int j = 0; j < k; j++)
                        send_m(f[j], (j == k - 1) ? TO + $urandom_range(3, 8)
                                                  : $urandom_range(0, 4));
                end
            endcase
        end
        repeat (TO + 5) @(negedge bclk);
        if (m_act) begin
            exp_err++;
            m_act = 1'b0;
        end
        check("rnd_wr_count", wr_q.size() - wq0, exp_q.size());
        check("rnd_err_count", err_cnt - e0, exp_err);
        for (int i = 0; i < exp_q.size() && wq0 + i < wr_q.size(); i++)
            check($sformatf("rnd_wr%0d", i), wr_q[wq0 + i], exp_q[i]);

        check("no_overlap", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
